// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one blocking single-ported cache between an I-fetch and a D port.
// Optional performance counters are enabled by defining CACHE_ARB_PERF_CNT_EN.
module cache_req_arbiter #(
    parameter int ADDR_LEN  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_LEN-1:0] i_addr,
    output logic [31:0]         i_rdata,
    output logic                i_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_LEN-1:0] d_addr,
    input  logic [31:0]         d_wdata,
    output logic [31:0]         d_rdata,
    output logic                d_ack,
    output logic [ADDR_LEN-1:0] c_addr,
    output logic                c_rd_req,
    output logic                c_wr_req,
    output logic [31:0]         c_wr_data,
    input  logic                c_miss,
    input  logic [31:0]         c_rd_data
`ifdef CACHE_ARB_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] i_grant_cnt,
    output logic [CNT_WIDTH-1:0] d_grant_cnt,
    output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic       {PORT_I, PORT_D}   port_t;

    state_t              state, state_nxt;
    port_t               owner, last_grant, grant;
    logic [ADDR_LEN-1:0] op_addr;
    logic                op_we;
    logic [31:0]         op_wdata;

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    // On a tie the port that did not win last time gets the cache.
    always_comb begin
        grant = PORT_I;
        if (i_req && d_req)
            grant = (last_grant == PORT_I) ? PORT_D : PORT_I;
        else if (d_req)
            grant = PORT_D;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_req || d_req) state_nxt = BUSY;
            BUSY:    if (!c_miss)        state_nxt = DONE;
            DONE:                        state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        c_addr    = '0;
        c_wr_data = '0;
        c_rd_req  = 1'b0;
        c_wr_req  = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;
        case (state)
            BUSY: begin
                c_addr    = op_addr;
                c_wr_data = op_wdata;
                c_rd_req  = ~op_we;
                c_wr_req  = op_we;
            end
            DONE: begin
                if (owner == PORT_I) begin
                    i_ack   = 1'b1;
                    i_rdata = c_rd_data;
                end else begin
                    d_ack   = 1'b1;
                    d_rdata = op_we ? 32'h0 : c_rd_data;
                end
            end
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= PORT_I;
            last_grant <= PORT_D;
            op_addr    <= '0;
            op_we      <= 1'b0;
            op_wdata   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (i_req || d_req)) begin
                owner <= grant;
                if (grant == PORT_I) begin
                    op_addr  <= i_addr;
                    op_we    <= 1'b0;
                    op_wdata <= '0;
                end else begin
                    op_addr  <= d_addr;
                    op_we    <= d_we;
                    op_wdata <= d_wdata;
                end
            end
            if (state == DONE)
                last_grant <= owner;
        end
    end

`ifdef CACHE_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_grant_cnt <= '0;
            d_grant_cnt <= '0;
            stall_cnt   <= '0;
        end else begin
            if (state == IDLE && (i_req || d_req)) begin
                if (grant == PORT_I) i_grant_cnt <= i_grant_cnt + CNT_WIDTH'(1);
                else                 d_grant_cnt <= d_grant_cnt + CNT_WIDTH'(1);
            end
            if (state == BUSY && c_miss)
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Scoreboard bench for cache_req_arbiter with a small behavioural blocking-cache model.
// Define CACHE_ARB_PERF_CNT_EN to also exercise the performance counters.
module tb_cache_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
    logic [31:0] i_rdata, d_rdata, c_addr, c_wr_data, c_rd_data;
    logic        i_ack, d_ack, c_rd_req, c_wr_req, c_miss;
`ifdef CACHE_ARB_PERF_CNT_EN
    logic [31:0] i_grant_cnt, d_grant_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    cache_req_arbiter #(.ADDR_LEN(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req),
        .c_wr_data(c_wr_data), .c_miss(c_miss), .c_rd_data(c_rd_data)
`ifdef CACHE_ARB_PERF_CNT_EN
        , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .stall_cnt(stall_cnt)
`endif
    );

    // Cache model: word-granular lines, miss held for miss_lat cycles on a cold line.
    logic [31:0] mem     [256];
    bit          written [256];
    bit          vld     [256];
    int          miss_cnt;
    int          miss_lat = 0;
    logic [7:0]  line;

    function automatic logic [31:0] init_word(input logic [7:0] l);
        return 32'hC0DE_0000 ^ {22'h0, l, 2'b00};
    endfunction

    assign line = c_addr[9:2];

    always_comb c_miss = (c_rd_req || c_wr_req) && !vld[line] && (miss_cnt < miss_lat);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            miss_cnt  <= 0;
            c_rd_data <= '0;
        end else if (c_rd_req || c_wr_req) begin
            if (c_miss) begin
                miss_cnt <= miss_cnt + 1;
            end else begin
                miss_cnt   <= 0;
                vld[line]  <= 1'b1;
                if (c_wr_req) begin
                    mem[line]     <= c_wr_data;
                    written[line] <= 1'b1;
                end else begin
                    c_rd_data <= written[line] ? mem[line] : init_word(line);
                end
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    typedef struct {
        bit          port_d;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    // Monitor: every ack pops one expectation and checks port, cycle and both rdata buses.
    always @(negedge clk) begin
        if (!rst) begin
            if (c_rd_req || c_wr_req)
                check("cache_req_onehot", 32'(c_rd_req ^ c_wr_req), 32'd1);
            if (i_ack || d_ack) begin
                if (i_ack && d_ack) begin
                    flag("both_acks_high");
                end else if (exp_q.size() == 0) begin
                    flag("unexpected_ack");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_port",    32'(d_ack), 32'(e.port_d));
                    check("ack_cycle",   32'(cyc), 32'(e.cyc));
                    check("owner_rdata", e.port_d ? d_rdata : i_rdata, e.rdata);
                    check("other_rdata", e.port_d ? i_rdata : d_rdata, 32'h0);
                end
            end
        end
    end

    task automatic wait_ack(input bit port_d, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = port_d ? d_ack : i_ack;
        end
        if (!ok) flag(port_d ? "d_ack_timeout" : "i_ack_timeout");
    endtask

    // One complete access from a requester: raise req, push the expectation, wait, drop.
    task automatic access(input bit port_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata, input int exp_lat);
        bit ok;
        @(posedge clk); #1;
        if (port_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        exp_q.push_back('{port_d, we ? 32'h0 : exp_rdata, cyc + 2 + exp_lat});
        wait_ack(port_d, ok);
        @(posedge clk); #1;
        if (port_d) d_req = 1'b0; else i_req = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        bit ok;
        int k;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_cache_ctrl", {28'h0, c_rd_req, c_wr_req, i_ack, d_ack}, 32'h0);
        check("reset_c_addr", c_addr, 32'h0);
        check("reset_rdata", i_rdata | d_rdata, 32'h0);

        // Cold I fetch of 0x40 with a 4-cycle refill.
        miss_lat = 4;
        access(1'b0, 1'b0, 32'h40, 32'h0, 32'hC0DE_0040, 4);

        // D write then I read of the same word, both hits.
        miss_lat = 0;
        access(1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 32'h0, 0);
        access(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);

        // Both ports continuously requesting hits: I,D,I,D... every 3 cycles.
        do_reset();
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        k = cyc;
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back('{1'b0, 32'hDEAD_BEEF, k + 2 + 6 * j});
            exp_q.push_back('{1'b1, 32'hDEAD_BEEF, k + 5 + 6 * j});
        end
        fork
            begin
                bit okf;
                for (int j = 0; j < 4; j++) wait_ack(1'b0, okf);
                @(posedge clk); #1 i_req = 1'b0;
            end
            begin
                bit okf;
                for (int j = 0; j < 4; j++) wait_ack(1'b1, okf);
                @(posedge clk); #1 d_req = 1'b0;
            end
        join

        // Reset during a miss: access is abandoned without an ack.
        miss_lat = 6;
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("rst_busy_cache_ctrl", {28'h0, c_rd_req, c_wr_req, i_ack, d_ack}, 32'h0);
        check("rst_busy_addr_data", c_addr | c_wr_data, 32'h0);
        check("rst_busy_rdata", i_rdata | d_rdata, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (4) @(posedge clk);
        miss_lat = 0;
        access(1'b1, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);

        // Address change after sampling must not reach the cache.
        @(posedge clk); #1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        exp_q.push_back('{1'b1, 32'hDEAD_BEEF, cyc + 2});
        @(posedge clk); #1 d_addr = 32'h80;
        @(negedge clk);
        check("latched_c_addr", c_addr, 32'h40);
        check("latched_rd_req", 32'(c_rd_req), 32'd1);
        wait_ack(1'b1, ok);
        @(posedge clk); #1 d_req = 1'b0;

`ifdef CACHE_ARB_PERF_CNT_EN
        do_reset();
        for (int j = 0; j < 3; j++) access(1'b0, 1'b0, 32'h40, 32'h0, 32'hDEAD_BEEF, 0);
        miss_lat = 20;
        access(1'b1, 1'b0, 32'h240, 32'h0, 32'hC0DE_0240, 20);
        @(negedge clk);
        check("i_grant_cnt", i_grant_cnt, 32'd3);
        check("d_grant_cnt", d_grant_cnt, 32'd1);
        check("stall_cnt",   stall_cnt,   32'd20);
`endif

        repeat (5) @(posedge clk);
        check("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
